// File: rtl/bsg_cgol_job_arbiter.sv
// Round-robin arbiter sharing one Game-of-Life engine among num_req_p requesters.
// Define BSG_CGOL_ARB_TIMEOUT_EN to enable the drain watchdog driving err_o.
module bsg_cgol_job_arbiter #(
    parameter int num_req_p    = 4,
    parameter int data_width_p = 64,
    parameter int in_words_p   = 16,
    parameter int out_words_p  = 15,
    parameter int timeout_p    = 65535
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic                              en_i,
    input  logic [num_req_p-1:0]              req_v_i,
    input  logic [num_req_p*data_width_p-1:0] req_data_i,
    output logic [num_req_p-1:0]              req_ready_o,
    output logic                              eng_v_o,
    output logic [data_width_p-1:0]           eng_data_o,
    input  logic                              eng_ready_i,
    input  logic                              eng_v_i,
    input  logic [data_width_p-1:0]           eng_data_i,
    output logic                              eng_yumi_o,
    output logic                              resp_v_o,
    output logic [data_width_p-1:0]           resp_data_o,
    output logic [$clog2(num_req_p)-1:0]      resp_id_o,
    input  logic                              resp_yumi_i,
    output logic                              busy_o,
    output logic                              err_o
);

    localparam int ID_W   = $clog2(num_req_p);
    localparam int IN_CW  = (in_words_p > 1) ? $clog2(in_words_p) : 1;
    localparam int OUT_CW = (out_words_p > 1) ? $clog2(out_words_p) : 1;

    localparam logic [IN_CW-1:0]  IN_LAST  = IN_CW'(in_words_p - 1);
    localparam logic [OUT_CW-1:0] OUT_LAST = OUT_CW'(out_words_p - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     grant_q, grant_d;
    logic [ID_W-1:0]     last_q, last_d;
    logic [IN_CW-1:0]    in_cnt_q, in_cnt_d;
    logic [OUT_CW-1:0]   out_cnt_q, out_cnt_d;

    logic                pick_v;
    logic [ID_W-1:0]     pick_id;
    logic [ID_W-1:0]     cand;
    logic                in_hs;
    logic                out_hs;

`ifdef BSG_CGOL_ARB_TIMEOUT_EN
    localparam int WD_W = (timeout_p > 0) ? $clog2(timeout_p + 1) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(timeout_p);

    logic [WD_W-1:0]     wd_q, wd_d;
    logic                err_q, err_d;
    logic                wd_hit;
`endif

    // Round-robin pick: first requester at or after last_q+1, wrapping.
    always_comb begin
        pick_v  = 1'b0;
        pick_id = '0;
        cand    = '0;
        for (int i = 1; i <= num_req_p; i++) begin
            cand = ID_W'((int'(last_q) + i) % num_req_p);
            if (!pick_v && req_v_i[cand]) begin
                pick_v  = 1'b1;
                pick_id = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        in_cnt_d    = in_cnt_q;
        out_cnt_d   = out_cnt_q;
        eng_v_o     = 1'b0;
        eng_data_o  = '0;
        req_ready_o = '0;
        resp_v_o    = 1'b0;
        resp_data_o = '0;
        eng_yumi_o  = 1'b0;
        in_hs       = 1'b0;
        out_hs      = 1'b0;
`ifdef BSG_CGOL_ARB_TIMEOUT_EN
        wd_d        = '0;
        err_d       = err_q;
        wd_hit      = 1'b0;
`endif

        // Outputs are forced low while reset is asserted, before state is known.
        if (reset_n_i) begin
            unique case (state_q)
                IDLE: begin
                    if (en_i && pick_v) begin
                        grant_d = pick_id;
                        state_d = LOAD;
                    end
                end

                LOAD: begin
                    eng_v_o              = req_v_i[grant_q];
                    eng_data_o           = req_data_i[int'(grant_q)*data_width_p +: data_width_p];
                    req_ready_o[grant_q] = eng_ready_i;
                    in_hs                = eng_v_o & eng_ready_i;
                    if (in_hs) begin
                        if (in_cnt_q == IN_LAST) begin
                            in_cnt_d = '0;
                            state_d  = DRAIN;
                        end else begin
                            in_cnt_d = in_cnt_q + 1'b1;
                        end
                    end
                end

                DRAIN: begin
                    resp_v_o    = eng_v_i;
                    resp_data_o = eng_data_i;
                    eng_yumi_o  = resp_yumi_i & eng_v_i;
                    out_hs      = eng_yumi_o;
                    if (out_hs) begin
                        if (out_cnt_q == OUT_LAST) begin
                            out_cnt_d = '0;
                            last_d    = grant_q;
                            state_d   = IDLE;
                        end else begin
                            out_cnt_d = out_cnt_q + 1'b1;
                        end
                    end
`ifdef BSG_CGOL_ARB_TIMEOUT_EN
                    else if (wd_q == WD_MAX) begin
                        wd_hit    = 1'b1;
                        err_d     = 1'b1;
                        out_cnt_d = '0;
                        last_d    = grant_q;
                        state_d   = IDLE;
                    end else begin
                        wd_d = wd_q + 1'b1;
                    end
`endif
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            last_q    <= ID_W'(num_req_p - 1);
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
        end
    end

`ifdef BSG_CGOL_ARB_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    // The expiring cycle itself already flags the error.
    assign err_o = reset_n_i & (err_q | wd_hit);
`else
    logic unused_timeout;
    assign unused_timeout = (timeout_p != 0);
    assign err_o          = 1'b0;
`endif

    assign resp_id_o = reset_n_i ? grant_q : '0;
    assign busy_o    = reset_n_i & (state_q != IDLE);

endmodule

// File: tb/tb_bsg_cgol_job_arbiter.sv
// Scoreboard bench for bsg_cgol_job_arbiter: directed jobs, expected words queued
// at issue time and compared by an independent monitor.
module tb_bsg_cgol_job_arbiter;

    localparam int NR = 4;
    localparam int DW = 64;
    localparam int IW = 16;
    localparam int OW = 15;
    localparam int TO = 100;

    logic              clk_i = 1'b0;
    logic              reset_n_i = 1'b0;
    logic              en_i = 1'b1;
    logic [NR-1:0]     req_v_i = '0;
    logic [NR*DW-1:0]  req_data_i = '0;
    logic [NR-1:0]     req_ready_o;
    logic              eng_v_o;
    logic [DW-1:0]     eng_data_o;
    logic              eng_ready_i = 1'b1;
    logic              eng_v_i = 1'b0;
    logic [DW-1:0]     eng_data_i = '0;
    logic              eng_yumi_o;
    logic              resp_v_o;
    logic [DW-1:0]     resp_data_o;
    logic [1:0]        resp_id_o;
    logic              resp_yumi_i = 1'b1;
    logic              busy_o;
    logic              err_o;

    always #5 clk_i = ~clk_i;

    bsg_cgol_job_arbiter #(
        .num_req_p   (NR),
        .data_width_p(DW),
        .in_words_p  (IW),
        .out_words_p (OW),
        .timeout_p   (TO)
    ) dut (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .en_i       (en_i),
        .req_v_i    (req_v_i),
        .req_data_i (req_data_i),
        .req_ready_o(req_ready_o),
        .eng_v_o    (eng_v_o),
        .eng_data_o (eng_data_o),
        .eng_ready_i(eng_ready_i),
        .eng_v_i    (eng_v_i),
        .eng_data_i (eng_data_i),
        .eng_yumi_o (eng_yumi_o),
        .resp_v_o   (resp_v_o),
        .resp_data_o(resp_data_o),
        .resp_id_o  (resp_id_o),
        .resp_yumi_i(resp_yumi_i),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    typedef struct {
        logic [1:0]    id;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          exp_in[$];
    exp_t          exp_out[$];
    logic [DW-1:0] eng_q[$];

    int            add_jobs[NR];
    int            done_jobs[NR];
    int            jcnt[NR];
    int            wcnt[NR];
    int            xj[NR];
    logic [NR-1:0] hold_v = '0;
    bit            rdy_toggle = 1'b0;
    bit            yumi_hold = 1'b0;
    bit            eng_silent = 1'b0;

    int            n_chk = 0;
    int            n_fail = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endfunction

    function automatic logic [DW-1:0] in_word(input int k, input int j, input int w);
        return {8'(k), 8'hA5, 16'(j), 16'h0000, 16'(w)};
    endfunction

    function automatic logic [DW-1:0] res_word(input int k, input int j, input int w);
        return {8'(k), 8'h5A, 16'(j), 16'h0000, 16'(w)};
    endfunction

    task automatic expect_job(input int k);
        exp_t e;
        for (int w = 0; w < IW; w++) begin
            e.id = 2'(k);
            e.data = in_word(k, xj[k], w);
            exp_in.push_back(e);
        end
        for (int j = 0; j < OW; j++) begin
            e.id = 2'(k);
            e.data = res_word(k, xj[k], j);
            exp_out.push_back(e);
        end
        xj[k]++;
    endtask

    // Requesters and engine model: drive after negedge, sample handshakes before posedge.
    initial begin
        bit tog;
        logic [DW-1:0] w0;
        tog = 1'b0;
        forever begin
            @(negedge clk_i);
            #1;
            tog = ~tog;
            for (int k = 0; k < NR; k++) begin
                req_v_i[k] = (done_jobs[k] < add_jobs[k]) && !hold_v[k];
                req_data_i[k*DW +: DW] = in_word(k, jcnt[k], wcnt[k]);
            end
            eng_ready_i = rdy_toggle ? tog : 1'b1;
            eng_v_i = !eng_silent && (eng_q.size() > 0);
            eng_data_i = (eng_q.size() > 0) ? eng_q[0] : '0;
            resp_yumi_i = !yumi_hold;
            #3;
            if (!reset_n_i) begin
                for (int k = 0; k < NR; k++) begin
                    if (wcnt[k] != 0) jcnt[k]++;
                    wcnt[k] = 0;
                    done_jobs[k] = add_jobs[k];
                end
                eng_q.delete();
            end else begin
                for (int k = 0; k < NR; k++) begin
                    if (req_v_i[k] && req_ready_o[k]) begin
                        if (wcnt[k] == 0) begin
                            w0 = req_data_i[k*DW +: DW];
                            for (int j = 0; j < OW; j++)
                                eng_q.push_back({w0[63:56], 8'h5A, w0[47:16], 16'(j)});
                        end
                        wcnt[k]++;
                        if (wcnt[k] == IW) begin
                            wcnt[k] = 0;
                            jcnt[k]++;
                            done_jobs[k]++;
                        end
                    end
                end
                if (eng_yumi_o && eng_q.size() > 0) void'(eng_q.pop_front());
            end
        end
    end

    // Monitor: compares every word the DUT hands over against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            #4;
            if (eng_v_o && eng_ready_i) begin
                if (exp_in.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL in_extra: got word %h with nothing expected", eng_data_o);
                end else begin
                    e = exp_in.pop_front();
                    chk("in_data", eng_data_o, e.data);
                    chk("req_ready_grant", 64'(req_ready_o), 64'(4'b0001 << e.id));
                end
            end
            if (eng_v_o && !eng_ready_i) chk("req_ready_low", 64'(req_ready_o), 0);
            if (eng_v_o) chk("load_no_resp", {resp_v_o, eng_yumi_o}, 0);
            if (resp_v_o && resp_yumi_i) begin
                if (exp_out.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL resp_extra: got word %h with nothing expected", resp_data_o);
                end else begin
                    e = exp_out.pop_front();
                    chk("resp_data", resp_data_o, e.data);
                    chk("resp_id", 64'(resp_id_o), 64'(e.id));
                    chk("eng_yumi", 64'(eng_yumi_o), 1);
                end
            end
            if (resp_v_o && !resp_yumi_i) chk("yumi_held", 64'(eng_yumi_o), 0);
        end
    end

    task automatic wait_in(input string nm, input int le);
        int n = 0;
        while (exp_in.size() > le && n < 2000) begin
            @(negedge clk_i);
            n++;
        end
        chk(nm, 64'(exp_in.size() > le), 0);
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        do begin
            @(negedge clk_i);
            #3;
            n++;
        end while (!(exp_in.size() == 0 && exp_out.size() == 0 && !busy_o) && n < 2000);
        chk(nm, {exp_in.size() == 0, exp_out.size() == 0, !busy_o}, 3'b111);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, %0d checks so far", n_chk);
        $fatal(1, "bench time limit reached");
    end

    initial begin
        // Reset: every output low
        repeat (3) @(negedge clk_i);
        #3;
        chk("rst_busy", 64'(busy_o), 0);
        chk("rst_eng_v", 64'(eng_v_o), 0);
        chk("rst_req_ready", 64'(req_ready_o), 0);
        chk("rst_resp_v", 64'(resp_v_o), 0);
        chk("rst_resp_id", 64'(resp_id_o), 0);
        chk("rst_eng_yumi", 64'(eng_yumi_o), 0);
        chk("rst_err", 64'(err_o), 0);

        // Requests 0101: requester 0 first, then 2
        @(negedge clk_i);
        reset_n_i = 1'b1;
        expect_job(0);
        expect_job(2);
        add_jobs[0]++;
        add_jobs[2]++;
        wait_done("t1_done");

        // Fresh reset, all four busy for two jobs each: 0,1,2,3,0,1,2,3
        @(negedge clk_i);
        reset_n_i = 1'b0;
        @(negedge clk_i);
        reset_n_i = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < NR; k++) expect_job(k);
        for (int k = 0; k < NR; k++) add_jobs[k] += 2;
        wait_done("t2_done");

        // Toggling engine ready; requester 3 waits while 1 loads
        @(negedge clk_i);
        rdy_toggle = 1'b1;
        expect_job(1);
        expect_job(3);
        add_jobs[1]++;
        add_jobs[3]++;
        wait_done("t3_done");

        // Response consumer stalls 20 cycles in DRAIN
        @(negedge clk_i);
        rdy_toggle = 1'b0;
        yumi_hold = 1'b1;
        expect_job(0);
        add_jobs[0]++;
        wait_in("t4_load", 0);
        repeat (20) begin
            @(negedge clk_i);
            #3;
            chk("t4_yumi_low", 64'(eng_yumi_o), 0);
            chk("t4_resp_v", 64'(resp_v_o), 1);
        end
        chk("t4_none_lost", 64'(exp_out.size()), 64'(OW));
        @(negedge clk_i);
        yumi_hold = 1'b0;
        wait_done("t4_done");

        // en_i low blocks new grants only
        @(negedge clk_i);
        en_i = 1'b0;
        add_jobs[1]++;
        repeat (8) begin
            @(negedge clk_i);
            #3;
            chk("t5_blocked", 64'(busy_o), 0);
        end
        @(negedge clk_i);
        expect_job(1);
        en_i = 1'b1;
        #3;
        chk("t5_arb_cycle", 64'(busy_o), 0);
        @(negedge clk_i);
        #3;
        chk("t5_first_load", {busy_o, eng_v_o}, 2'b11);
        wait_in("t5_mid", 8);
        @(negedge clk_i);
        en_i = 1'b0;
        add_jobs[2]++;
        wait_done("t5_job_completes");
        repeat (6) begin
            @(negedge clk_i);
            #3;
            chk("t5_stay_idle", 64'(busy_o), 0);
        end
        @(negedge clk_i);
        expect_job(2);
        en_i = 1'b1;
        wait_done("t5_done");

        // Granted requester drops valid mid-load and keeps the grant
        @(negedge clk_i);
        expect_job(3);
        expect_job(0);
        add_jobs[3]++;
        add_jobs[0]++;
        wait_in("t6_load", 28);
        @(negedge clk_i);
        hold_v = 4'b1000;
        repeat (8) begin
            @(negedge clk_i);
            #3;
            chk("t6_eng_v", 64'(eng_v_o), 0);
            chk("t6_grant_kept", 64'(req_ready_o), 64'(4'b1000));
        end
        @(negedge clk_i);
        hold_v = '0;
        wait_done("t6_done");

`ifdef BSG_CGOL_ARB_TIMEOUT_EN
        // Silent engine in DRAIN trips the watchdog
        @(negedge clk_i);
        eng_silent = 1'b1;
        expect_job(1);
        add_jobs[1]++;
        wait_in("to_load", 0);
        for (int c = 0; c <= 101; c++) begin
            #3;
            if (c == 99) chk("to_err_before", 64'(err_o), 0);
            if (c == 100) chk("to_err_set", 64'(err_o), 1);
            if (c == 101) begin
                chk("to_idle", 64'(busy_o), 0);
                chk("to_err_sticky", 64'(err_o), 1);
            end
            @(negedge clk_i);
        end
        exp_out.delete();
        eng_silent = 1'b0;
`endif

        // Reset mid-load abandons the job; last_q returns to num_req_p-1
        @(negedge clk_i);
        expect_job(2);
        add_jobs[2]++;
        wait_in("t7_load", 10);
        @(negedge clk_i);
        reset_n_i = 1'b0;
        exp_in.delete();
        exp_out.delete();
        @(negedge clk_i);
        #3;
        chk("t7_rst_busy", 64'(busy_o), 0);
        chk("t7_rst_err", 64'(err_o), 0);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        #3;
        chk("t7_idle", 64'(busy_o), 0);
        chk("t7_err_clear", 64'(err_o), 0);
        @(negedge clk_i);
        expect_job(1);
        expect_job(3);
        add_jobs[1]++;
        add_jobs[3]++;
        wait_done("t7_done");

        @(negedge clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
